step_sched: RTL and testbench

//  Controller for the 8-step drum sequencer datapath. Stores an 8-step x 3-voice

---
 rtl/step_sched_pkg.sv | 14 +
 rtl/seq_prescaler.sv | 34 +++
 rtl/step_sched.sv | 163 ++++++++++++++++
 tb/tb_step_sched.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/step_sched_pkg.sv
// Shared definitions for the step sequencer controller: FSM states and pattern geometry.
package step_sched_pkg;

    localparam int unsigned STEPS  = 8;
    localparam int unsigned VOICES = 3;
    localparam int unsigned STEP_W = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

endpackage

// File: rtl/seq_prescaler.sv
// Base-tick prescaler: emits a 1-clk pulse every PRE_DIV clocks; a synchronous clear restarts the count.
module seq_prescaler #(
    parameter int unsigned PRE_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CW = $clog2(PRE_DIV);
    localparam logic [CW-1:0] LAST = CW'(PRE_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Pulse is not masked by clr_i so the step logic can use it to decide on clearing.
    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/step_sched.sv
// 8-step x 3-voice drum sequencer controller. Optional swing timing enabled by `SWING_EN.
module step_sched
    import step_sched_pkg::*;
#(
    parameter int unsigned PRE_DIV  = 1000,
    parameter int unsigned GATE_LEN = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [7:0]        tempo,
    input  logic              pat_we,
    input  logic [STEP_W-1:0] pat_addr,
    input  logic [VOICES-1:0] pat_data,
`ifdef SWING_EN
    input  logic [3:0]        swing,
`endif
    output logic [STEPS-1:0]  sel,
    output logic [VOICES-1:0] tick,
    output logic              step_strobe,
    output logic              busy
);

    localparam int unsigned GW = $clog2(GATE_LEN + 1);

    state_t            state_q, state_d;
    logic              start_q, start_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [STEPS-1:0]  sel_q, sel_d;
    logic [VOICES-1:0] tick_q, tick_d;
    logic              strobe_q, strobe_d;
    logic [GW-1:0]     gate_q, gate_d;
    logic [8:0]        tcnt_q, tcnt_d;
    logic [8:0]        per_q, per_d;
    logic [VOICES-1:0] pat_q [STEPS];

    logic              base_tick;
    logic              entry;
    logic              pre_clr;
    logic [STEP_W-1:0] nstep;
    logic [8:0]        period_m1;

    seq_prescaler #(.PRE_DIV(PRE_DIV)) u_pre (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (pre_clr),
        .tick_o (base_tick)
    );

    assign nstep = start_q ? '0 : step_q + 1'b1;

    // Step period in base ticks minus one, for the step about to be entered.
    always_comb begin
        period_m1 = {1'b0, tempo};
`ifdef SWING_EN
        if (!nstep[0]) begin
            period_m1 = {1'b0, tempo} + {5'b0, swing};
        end else if ({4'b0, swing} >= tempo) begin
            period_m1 = '0;
        end else begin
            period_m1 = {1'b0, tempo - {4'b0, swing}};
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        step_d   = step_q;
        sel_d    = sel_q;
        tick_d   = tick_q;
        strobe_d = 1'b0;
        tcnt_d   = tcnt_q;
        per_d    = per_q;
        entry    = 1'b0;
        gate_d   = (gate_q != '0) ? gate_q - 1'b1 : '0;
        if (gate_q <= GW'(1)) begin
            tick_d = '0;
        end

        unique case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = RUN;
                    start_d = 1'b1;
                end
            end
            RUN: begin
                if (!run) begin
                    state_d = STOPPING;
                    start_d = 1'b0;
                end else if (start_q || (base_tick && tcnt_q == per_q)) begin
                    entry = 1'b1;
                end else if (base_tick) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            STOPPING: begin
                if (run) begin
                    state_d = RUN;
                    start_d = 1'b1;
                end else if (gate_q <= GW'(1)) begin
                    state_d = IDLE;
                    sel_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (entry) begin
            start_d  = 1'b0;
            step_d   = nstep;
            sel_d    = STEPS'(1) << nstep;
            tick_d   = pat_q[nstep];
            gate_d   = GW'(GATE_LEN);
            tcnt_d   = '0;
            per_d    = period_m1;
            strobe_d = 1'b1;
        end
    end

    assign pre_clr = entry || (state_q != RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            step_q   <= '0;
            sel_q    <= '0;
            tick_q   <= '0;
            strobe_q <= 1'b0;
            gate_q   <= '0;
            tcnt_q   <= '0;
            per_q    <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            step_q   <= step_d;
            sel_q    <= sel_d;
            tick_q   <= tick_d;
            strobe_q <= strobe_d;
            gate_q   <= gate_d;
            tcnt_q   <= tcnt_d;
            per_q    <= per_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < STEPS; i++) begin
                pat_q[i] <= '0;
            end
        end else if (pat_we) begin
            pat_q[pat_addr] <= pat_data;
        end
    end

    assign sel         = sel_q;
    assign tick        = tick_q;
    assign step_strobe = strobe_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_step_sched.sv
// Randomized scoreboard bench for step_sched; exercises swing timing when built with SWING_EN.
module tb_step_sched;

    localparam int PRE_DIV  = 4;
    localparam int GATE_LEN = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [7:0] tempo;
    logic       pat_we;
    logic [2:0] pat_addr;
    logic [2:0] pat_data;
`ifdef SWING_EN
    logic [3:0] swing;
`endif
    logic [7:0] sel;
    logic [2:0] tick;
    logic       step_strobe;
    logic       busy;

    step_sched #(.PRE_DIV(PRE_DIV), .GATE_LEN(GATE_LEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .tempo       (tempo),
        .pat_we      (pat_we),
        .pat_addr    (pat_addr),
        .pat_data    (pat_data),
`ifdef SWING_EN
        .swing       (swing),
`endif
        .sel         (sel),
        .tick        (tick),
        .step_strobe (step_strobe),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: absolute times of step entries and gate ends, in clock edges.
    typedef struct { int t; logic [7:0] sel; logic [2:0] tick; } ent_t;
    ent_t exp_q[$];

    int         t = 0;
    int         mode = 0;      // 0 idle, 1 playing, 2 stopping
    int         next_t = 0;
    int         gate_end = 0;
    int         mstep = 0;
    bit         restart = 0;
    logic [2:0] mpat [8];
    logic [7:0] m_sel = '0;
    logic [2:0] ent_tick = '0;
    bit         m_strobe = 0;

    function automatic int period_clks(input int step, input int tp, input int sw);
        int base;
        base = tp + 1;
`ifdef SWING_EN
        if (step % 2 == 0) base = tp + 1 + sw;
        else               base = tp + 1 - ((sw < tp) ? sw : tp);
`endif
        return base * PRE_DIV;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mode = 0; next_t = 0; gate_end = 0; mstep = 0; restart = 0;
            m_sel = '0; ent_tick = '0; m_strobe = 0;
            for (int i = 0; i < 8; i++) mpat[i] = '0;
            exp_q.delete();
        end else begin
            int sw;
            t++;
            m_strobe = 0;
            sw = 0;
`ifdef SWING_EN
            sw = int'(swing);
`endif
            case (mode)
                0: if (run) begin mode = 1; next_t = t + 1; restart = 1; end
                1: begin
                    if (!run) mode = 2;
                    else if (t == next_t) begin
                        mstep    = restart ? 0 : (mstep + 1) % 8;
                        restart  = 0;
                        m_sel    = 8'(1 << mstep);
                        ent_tick = mpat[mstep];
                        gate_end = t + GATE_LEN;
                        next_t   = t + period_clks(mstep, int'(tempo), sw);
                        m_strobe = 1;
                        exp_q.push_back('{t, m_sel, ent_tick});
                    end
                end
                default: begin
                    if (run) begin mode = 1; next_t = t + 1; restart = 1; end
                    else if (t >= gate_end) begin mode = 0; m_sel = '0; end
                end
            endcase
            if (pat_we) mpat[pat_addr] = pat_data;
        end
    end

    // Monitor: per-cycle output checks, and a scoreboard pop on every step entry.
    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(mode != 0));
        check("sel", 32'(sel), 32'(m_sel));
        check("tick", 32'(tick), (t < gate_end) ? 32'(ent_tick) : 32'h0);
        check("strobe", 32'(step_strobe), 32'(m_strobe));
        if (step_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("entry_unexpected", 32'h1, 32'h0);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                check("entry_time", 32'(t), 32'(e.t));
                check("entry_sel", 32'(sel), 32'(e.sel));
                check("entry_tick", 32'(tick), 32'(e.tick));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [2:0] a, input logic [2:0] d);
        pat_we = 1'b1; pat_addr = a; pat_data = d;
        @(posedge clk); #1;
        pat_we = 1'b0;
    endtask

    task automatic wait_step(input logic [7:0] s, input int budget);
        bit found;
        found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (step_strobe === 1'b1 && sel === s) found = 1;
        end
        check("wait_step", 32'(found), 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; run = 1'b0; tempo = '0; pat_we = 1'b0; pat_addr = '0; pat_data = '0;
`ifdef SWING_EN
        swing = '0;
`endif
        cyc(3);
        rst = 1'b0;
        cyc(2);

        // Empty pattern: steps advance, no triggers
        run = 1'b1; cyc(20);
        run = 1'b0; cyc(6);

        wr(3'd0, 3'b001); wr(3'd1, 3'b010); wr(3'd2, 3'b100);

        // tempo 0: full wrap of the pattern
        run = 1'b1; cyc(70);
        // tempo 2, then changes mid-step
        tempo = 8'd2; cyc(40);
        tempo = 8'd0; cyc(5);
        tempo = 8'd1; cyc(30);
        tempo = 8'd0; cyc(20);

        // stop right after step-0 entry, full drain to idle
        wait_step(8'h01, 200);
        run = 1'b0;
        cyc(8);
        // restart during the stopping gate
        run = 1'b1;
        wait_step(8'h01, 50);
        run = 1'b0;
        @(posedge clk); #1;
        run = 1'b1;
        cyc(20);

        // write current step during its gate; write next step on its entry edge
        wait_step(8'h01, 200);
        wr(3'd0, 3'b111);
        cyc(2);
        wr(3'd1, 3'b011);
        cyc(40);

`ifdef SWING_EN
        tempo = 8'd1; swing = 4'd1; cyc(60);
        swing = 4'd3; cyc(60);
        swing = 4'd0; tempo = 8'd0;
`endif

        // randomized play
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) run = ~run;
            if ($urandom_range(0, 29) == 0) tempo = 8'($urandom_range(0, 3));
`ifdef SWING_EN
            if ($urandom_range(0, 29) == 0) swing = 4'($urandom_range(0, 15));
`endif
            pat_we   = ($urandom_range(0, 4) == 0);
            pat_addr = 3'($urandom_range(0, 7));
            pat_data = 3'($urandom_range(0, 7));
            cyc(1);
        end
        pat_we = 1'b0;

        // reset in the middle of play
        run = 1'b1; tempo = 8'd0;
        wait_step(8'h01, 300);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        run = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(2);
        run = 1'b1; cyc(40);
        run = 1'b0; cyc(10);

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
